// File: rtl/noc_pkg.sv
// Shared types and flit layout for the NoC test-tile traffic generators.
// Flit builders keep the head and body/tail field placement in one place.
package noc_pkg;

    typedef enum logic [1:0] {
        FT_BODY = 2'b00,
        FT_HEAD = 2'b01,
        FT_TAIL = 2'b10
    } flit_type_e;

    typedef enum logic [1:0] {
        TG_IDLE,
        TG_HEAD,
        TG_BODY,
        TG_TAIL
    } tg_state_e;

    localparam int ADDR_W = 4;
    localparam int SEQ_W  = 8;
    localparam int IDX_W  = 8;

    localparam int TYPE_LSB    = 30;
    localparam int HD_DEST_LSB = 26;
    localparam int HD_SRC_LSB  = 22;
    localparam int HD_SEQ_LSB  = 14;
    localparam int BD_SRC_LSB  = 26;
    localparam int BD_SEQ_LSB  = 18;
    localparam int BD_IDX_LSB  = 10;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [31:0] head_flit(
        input logic [ADDR_W-1:0] dest,
        input logic [ADDR_W-1:0] src,
        input logic [SEQ_W-1:0]  seq
    );
        logic [31:0] f;
        f = '0;
        f[TYPE_LSB +: 2]         = FT_HEAD;
        f[HD_DEST_LSB +: ADDR_W] = dest;
        f[HD_SRC_LSB +: ADDR_W]  = src;
        f[HD_SEQ_LSB +: SEQ_W]   = seq;
        return f;
    endfunction

    function automatic logic [31:0] body_flit(
        input flit_type_e        t,
        input logic [ADDR_W-1:0] src,
        input logic [SEQ_W-1:0]  seq,
        input logic [IDX_W-1:0]  idx
    );
        logic [31:0] f;
        f = '0;
        f[TYPE_LSB +: 2]        = t;
        f[BD_SRC_LSB +: ADDR_W] = src;
        f[BD_SEQ_LSB +: SEQ_W]  = seq;
        f[BD_IDX_LSB +: IDX_W]  = idx;
        return f;
    endfunction

endpackage

// File: rtl/noc_lfsr16.sv
// 16-bit Fibonacci LFSR, shift left with feedback into bit 0.
// Advances only when step is high; shared by the tile generators.
module noc_lfsr16
    import noc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (step) begin
            q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/noc_traffic_gen.sv
// Synthetic wormhole packet injector for the NoC test tile.
// Define NOC_TG_CREDIT_EN for credit-based flow control instead of ready.
module noc_traffic_gen
    import noc_pkg::*;
#(
    parameter int FLIT_W    = 32,
    parameter int DEST_W    = 4,
    parameter int NODE_ID   = 0,
    parameter int NUM_NODES = 16,
    parameter int PKT_LEN   = 4,
    parameter int INJ_GAP   = 8
`ifdef NOC_TG_CREDIT_EN
    ,
    parameter int CREDITS   = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              i_flit_ready,
`ifdef NOC_TG_CREDIT_EN
    input  logic              i_credit,
`endif
    output logic              o_flit_valid,
    output logic [FLIT_W-1:0] o_flit,
    output logic [15:0]       o_pkt_cnt,
    output logic              o_busy
);

    if (FLIT_W != 32 || DEST_W > ADDR_W || DEST_W < 1) begin : g_bad_w
        $error("noc_traffic_gen: FLIT_W must be 32, DEST_W 1..4");
    end
    if (PKT_LEN < 2) begin : g_bad_len
        $error("noc_traffic_gen: PKT_LEN must be >= 2");
    end
    if (NUM_NODES < 2 || NUM_NODES > (1 << DEST_W)) begin : g_bad_nodes
        $error("noc_traffic_gen: NUM_NODES out of range");
    end

    localparam logic [15:0]      GAP_LAST  = 16'(INJ_GAP);
    localparam logic [IDX_W-1:0] IDX_LASTB = IDX_W'(PKT_LEN - 2);
    localparam logic [ADDR_W-1:0] SRC      = ADDR_W'(NODE_ID);
    localparam tg_state_e        AFTER_HD  = (PKT_LEN > 2) ? TG_BODY : TG_TAIL;
    localparam bit               B2B       = (INJ_GAP == 0);

    tg_state_e          state_q, state_d;
    logic [15:0]        gap_q, gap_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DEST_W-1:0]  dest_q, dest_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        lfsr_q;
    logic [DEST_W-1:0]  dest_pick;
    logic               step;
    logic               xfer;
    int                 dest_int;

    noc_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .q    (lfsr_q)
    );

    logic unused_lfsr;
    assign unused_lfsr = ^lfsr_q;

    // Destination comes from the LFSR value being stepped out on head entry
    always_comb begin
        dest_int = int'(32'(lfsr_q[DEST_W-1:0])) % NUM_NODES;
        if (dest_int == NODE_ID) begin
            dest_int = (dest_int + 1) % NUM_NODES;
        end
        dest_pick = DEST_W'(dest_int);
    end

`ifdef NOC_TG_CREDIT_EN
    localparam int            CW   = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);

    logic [CW-1:0] cred_q, cred_d;
    logic          unused_ready;

    assign unused_ready = i_flit_ready;
    assign xfer         = o_flit_valid && (cred_q != '0);

    always_comb begin
        cred_d = cred_q;
        if (xfer && !i_credit) begin
            cred_d = cred_q - 1'b1;
        end else if (!xfer && i_credit && cred_q != CMAX) begin
            cred_d = cred_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cred_q <= CMAX;
        end else begin
            cred_q <= cred_d;
        end
    end
`else
    assign xfer = o_flit_valid && i_flit_ready;
`endif

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        seq_d   = seq_q;
        idx_d   = idx_q;
        dest_d  = dest_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        unique case (state_q)
            TG_IDLE: begin
                if (en) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = TG_HEAD;
                        step    = 1'b1;
                        dest_d  = dest_pick;
                        idx_d   = IDX_W'(1);
                    end else begin
                        gap_d = gap_q + 16'd1;
                    end
                end
            end
            TG_HEAD: begin
                if (xfer) begin
                    state_d = AFTER_HD;
                end
            end
            TG_BODY: begin
                if (xfer) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LASTB) begin
                        state_d = TG_TAIL;
                    end
                end
            end
            TG_TAIL: begin
                if (xfer) begin
                    cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    seq_d = seq_q + SEQ_W'(1);
                    if (B2B && en) begin
                        state_d = TG_HEAD;
                        step    = 1'b1;
                        dest_d  = dest_pick;
                        idx_d   = IDX_W'(1);
                    end else begin
                        state_d = TG_IDLE;
                        gap_d   = '0;
                    end
                end
            end
            default: state_d = TG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TG_IDLE;
            gap_q   <= '0;
            seq_q   <= '0;
            idx_q   <= '0;
            dest_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            dest_q  <= dest_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        o_flit = '0;
        unique case (state_q)
            TG_HEAD: o_flit = head_flit(ADDR_W'(dest_q), SRC, seq_q);
            TG_BODY: o_flit = body_flit(FT_BODY, SRC, seq_q, idx_q);
            TG_TAIL: o_flit = body_flit(FT_TAIL, SRC, seq_q, idx_q);
            default: o_flit = '0;
        endcase
    end

    assign o_flit_valid = (state_q != TG_IDLE);
    assign o_busy       = (state_q != TG_IDLE);
    assign o_pkt_cnt    = cnt_q;

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed bench for noc_traffic_gen: gapped injector (A, node 0) and
// back-to-back injector (B, node 1, exercising the self-address skip).
module tb_noc_traffic_gen;

    logic        clk = 1'b0;
    logic        rst_a, en_a, rdy_a;
    logic        rst_b, en_b, rdy_b;
    logic        vld_a, busy_a, vld_b, busy_b;
    logic [31:0] flit_a, flit_b;
    logic [15:0] cnt_a, cnt_b;
`ifdef NOC_TG_CREDIT_EN
    logic        credit_a, credit_b;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    noc_traffic_gen #(
        .NODE_ID (0),
        .INJ_GAP (8),
        .PKT_LEN (4)
`ifdef NOC_TG_CREDIT_EN
        ,
        .CREDITS (2)
`endif
    ) dut_a (
        .clk          (clk),
        .rst          (rst_a),
        .en           (en_a),
        .i_flit_ready (rdy_a),
`ifdef NOC_TG_CREDIT_EN
        .i_credit     (credit_a),
`endif
        .o_flit_valid (vld_a),
        .o_flit       (flit_a),
        .o_pkt_cnt    (cnt_a),
        .o_busy       (busy_a)
    );

    noc_traffic_gen #(
        .NODE_ID (1),
        .INJ_GAP (0),
        .PKT_LEN (4)
    ) dut_b (
        .clk          (clk),
        .rst          (rst_b),
        .en           (en_b),
        .i_flit_ready (rdy_b),
`ifdef NOC_TG_CREDIT_EN
        .i_credit     (credit_b),
`endif
        .o_flit_valid (vld_b),
        .o_flit       (flit_b),
        .o_pkt_cnt    (cnt_b),
        .o_busy       (busy_b)
    );

    typedef struct {
        logic        en;
        logic        rdy;
        logic        vld;
        logic [31:0] flit;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic e, input logic r, input logic v,
                                input logic [31:0] f, input logic [15:0] c);
        vec_t t;
        t.en = e; t.rdy = r; t.vld = v; t.flit = f; t.cnt = c;
        return t;
    endfunction

    task automatic chk(input string name, input logic ok,
                       input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] hd(input logic [3:0] d, input logic [3:0] s,
                                       input logic [7:0] q);
        return {2'b01, d, s, q, 14'b0};
    endfunction

    function automatic logic [31:0] bd(input logic [1:0] t, input logic [3:0] s,
                                       input logic [7:0] q, input logic [7:0] i);
        return {t, s, q, i, 10'b0};
    endfunction

    logic [3:0] dest_b [10] = '{4'd2, 4'd3, 4'd7, 4'd15, 4'd14,
                                4'd12, 4'd9, 4'd2, 4'd4, 4'd8};

    initial begin
        int k;
        logic seen;
        logic [31:0] ef;
        rst_a = 1; en_a = 0; rdy_a = 1;
        rst_b = 1; en_b = 0; rdy_b = 1;
`ifdef NOC_TG_CREDIT_EN
        credit_a = 0; credit_b = 1;
`endif
        repeat (3) tick();
        chk("reset_a", !vld_a && !busy_a && flit_a == 0 && cnt_a == 0,
            {cnt_a, 14'b0, busy_a, vld_a, flit_a}, 64'h0);

`ifndef NOC_TG_CREDIT_EN
        for (int e = 1; e <= 8; e++) vq.push_back(mk(1, 1, 0, 32'h0, 0));
        vq.push_back(mk(1, 1, 1, 32'h4400_0000, 0));
        vq.push_back(mk(1, 1, 1, 32'h0000_0400, 0));
        for (int e = 11; e <= 15; e++) vq.push_back(mk(1, 0, 1, 32'h0000_0400, 0));
        vq.push_back(mk(1, 1, 1, 32'h0000_0800, 0));
        vq.push_back(mk(1, 1, 1, 32'h8000_0C00, 0));
        vq.push_back(mk(1, 1, 0, 32'h0, 1));
        for (int e = 19; e <= 26; e++) vq.push_back(mk(1, 1, 0, 32'h0, 1));
        vq.push_back(mk(1, 1, 1, 32'h4C00_4000, 1));
        vq.push_back(mk(1, 1, 1, 32'h0004_0400, 1));
        vq.push_back(mk(0, 1, 1, 32'h0004_0800, 1));
        vq.push_back(mk(0, 1, 1, 32'h8004_0C00, 1));
        vq.push_back(mk(0, 1, 0, 32'h0, 2));

        rst_a = 0;
        foreach (vq[i]) begin
            en_a = vq[i].en;
            rdy_a = vq[i].rdy;
            tick();
            chk($sformatf("vec_a[%0d]", i + 1),
                vld_a == vq[i].vld && busy_a == vq[i].vld &&
                flit_a == vq[i].flit && cnt_a == vq[i].cnt,
                {cnt_a, 14'b0, busy_a, vld_a, flit_a},
                {vq[i].cnt, 14'b0, vq[i].vld, vq[i].vld, vq[i].flit});
        end

        seen = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (vld_a || busy_a || cnt_a != 16'd2) seen = 1;
        end
        chk("en_off_quiet", !seen, {63'b0, seen}, 64'h0);

        en_a = 1;
        k = 0;
        while (k < 30 && !vld_a) begin
            tick();
            k++;
        end
        chk("p3_latency", k == 9, 64'(k), 64'd9);
        chk("p3_head", flit_a == 32'h5C00_8000, 64'(flit_a), 64'h5C00_8000);
        tick();
        chk("p3_body1", vld_a && flit_a == 32'h0008_0400,
            {31'b0, vld_a, flit_a}, {31'b0, 1'b1, 32'h0008_0400});
        rst_a = 1;
        tick();
        chk("rst_abort", !vld_a && !busy_a && flit_a == 0 && cnt_a == 0,
            {cnt_a, 14'b0, busy_a, vld_a, flit_a}, 64'h0);
        rst_a = 0;
        k = 0;
        while (k < 30 && !vld_a) begin
            tick();
            k++;
        end
        chk("rst_latency", k == 9, 64'(k), 64'd9);
        chk("rst_head", flit_a == 32'h4400_0000, 64'(flit_a), 64'h4400_0000);
`else
        rst_a = 0; en_a = 1; rdy_a = 0;
        k = 0;
        while (k < 30 && !vld_a) begin
            tick();
            k++;
        end
        chk("cr_latency", k == 9, 64'(k), 64'd9);
        chk("cr_head", flit_a == 32'h4400_0000, 64'(flit_a), 64'h4400_0000);
        repeat (6) tick();
        chk("cr_stall", vld_a && flit_a == 32'h0000_0800,
            {31'b0, vld_a, flit_a}, {31'b0, 1'b1, 32'h0000_0800});
        credit_a = 1;
        tick();
        credit_a = 0;
        chk("cr_ret_edge", flit_a == 32'h0000_0800, 64'(flit_a), 64'h0000_0800);
        tick();
        chk("cr_one_more", flit_a == 32'h8000_0C00, 64'(flit_a), 64'h8000_0C00);
        repeat (4) tick();
        chk("cr_stall2", vld_a && flit_a == 32'h8000_0C00 && cnt_a == 0,
            {cnt_a, 15'b0, vld_a, flit_a}, {16'h0, 15'b0, 1'b1, 32'h8000_0C00});
`endif

        chk("reset_b", !vld_b && !busy_b && flit_b == 0 && cnt_b == 0,
            {cnt_b, 14'b0, busy_b, vld_b, flit_b}, 64'h0);
        rst_b = 0; en_b = 1;
        tick();
        chk("b_latency", vld_b, {63'b0, vld_b}, 64'h1);
        for (int p = 0; p < 10; p++) begin
            for (int f = 0; f < 4; f++) begin
                if (f == 0) ef = hd(dest_b[p], 4'd1, 8'(p));
                else ef = bd((f == 3) ? 2'b10 : 2'b00, 4'd1, 8'(p), 8'(f));
                chk($sformatf("b_p%0d_f%0d", p, f),
                    vld_b && flit_b == ef && cnt_b == 16'(p),
                    {cnt_b, 15'b0, vld_b, flit_b}, {16'(p), 15'b0, 1'b1, ef});
                tick();
            end
        end
        chk("b_cnt10", cnt_b == 16'd10 && vld_b,
            {cnt_b, 15'b0, vld_b, 32'h0}, {16'd10, 15'b0, 1'b1, 32'h0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
